// File: rtl/sfp_prbs31_checker.sv
// PRBS31 (x^31+x^28+1) self-synchronising RX checker, lock FSM, saturating counters; 2-cycle latency, no backpressure.
// Define PRBS_CHK_BITCNT_EN to build the popcount and bit_err_cnt; otherwise bit_err_cnt is tied to 0.
module sfp_prbs31_checker #(
  parameter int DATA_W       = 64,
  parameter int LOCK_WORDS   = 16,
  parameter int UNLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              cnt_clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [31:0]       word_err_cnt,
  output logic [31:0]       bit_err_cnt,
  output logic [7:0]        lock_loss_cnt
);

  typedef enum logic [1:0] {ST_DOWN, ST_PRIME, ST_HUNT, ST_LOCKED} state_t;

  logic                accept;
  logic [2*DATA_W-1:0] ext;
  logic [DATA_W-1:0]   hist_d, hist_q;
  logic [DATA_W-1:0]   e_d, e_q;
  logic                acc_q, rdy_q;

  state_t      state_d, state_q;
  logic [7:0]  run_d, run_q;
  logic [7:0]  bad_d, bad_q;
  logic [31:0] word_d, word_q;
  logic [7:0]  loss_d, loss_q;
  logic        pulse_d, pulse_q;
  logic        err_w;

  assign accept = rx_ready & rx_valid;
  assign ext    = {rx_data, hist_q};

  // Upper half of ext is the current word; taps reach back into hist for low bits.
  always_comb begin
    e_d    = '0;
    hist_d = accept ? rx_data : hist_q;
    for (int i = 0; i < DATA_W; i++) begin
      e_d[i] = ext[DATA_W+i] ^ ext[DATA_W+i-28] ^ ext[DATA_W+i-31];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      e_q    <= '0;
      acc_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      e_q    <= e_d;
      acc_q  <= accept;
      rdy_q  <= rx_ready;
    end
  end

  assign err_w = |e_q;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    bad_d   = bad_q;
    word_d  = word_q;
    loss_d  = loss_q;
    pulse_d = 1'b0;
    if (!rdy_q) begin
      state_d = ST_DOWN;
      run_d   = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        ST_DOWN: begin
          // An accepted word here is the priming word: it only filled hist.
          state_d = acc_q ? ST_HUNT : ST_PRIME;
          run_d   = '0;
          bad_d   = '0;
        end
        ST_PRIME: begin
          if (acc_q) state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (acc_q) begin
            if (err_w) begin
              run_d = '0;
            end else if (run_q == 8'(LOCK_WORDS - 1)) begin
              state_d = ST_LOCKED;
              run_d   = '0;
              bad_d   = '0;
            end else begin
              run_d = run_q + 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (acc_q) begin
            if (err_w) begin
              pulse_d = 1'b1;
              word_d  = (&word_q) ? word_q : word_q + 32'd1;
              if (bad_q == 8'(UNLOCK_WORDS - 1)) begin
                state_d = ST_HUNT;
                bad_d   = '0;
                run_d   = '0;
                loss_d  = (&loss_q) ? loss_q : loss_q + 8'd1;
              end else begin
                bad_d = bad_q + 8'd1;
              end
            end else begin
              bad_d = '0;
            end
          end
        end
        default: state_d = ST_DOWN;
      endcase
    end
    if (cnt_clear) begin
      word_d = '0;
      loss_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DOWN;
      run_q   <= '0;
      bad_q   <= '0;
      word_q  <= '0;
      loss_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      bad_q   <= bad_d;
      word_q  <= word_d;
      loss_q  <= loss_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [7:0]  pop_w;
  logic [32:0] bit_sum;
  logic [31:0] bit_d, bit_q;

  always_comb begin
    pop_w = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop_w = pop_w + 8'(e_q[i]);
    end
    bit_sum = {1'b0, bit_q} + {25'd0, pop_w};
    bit_d   = bit_q;
    if (rdy_q && acc_q && err_w && state_q == ST_LOCKED) begin
      bit_d = bit_sum[32] ? '1 : bit_sum[31:0];
    end
    if (cnt_clear) bit_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bit_q <= '0;
    else          bit_q <= bit_d;
  end

  assign bit_err_cnt = bit_q;
`else
  assign bit_err_cnt = '0;
`endif

  assign locked        = (state_q == ST_LOCKED);
  assign err_pulse     = pulse_q;
  assign word_err_cnt  = word_q;
  assign lock_loss_cnt = loss_q;

endmodule
